// File: rtl/pov_pkg.sv
// Shared constants and types for the POV column driver.
//   - Glyph geometry: GLYPH_W lit columns per glyph, GLYPH_PITCH columns per
//     glyph slot (the extra column is a blank spacer), NUM_GLYPHS slots, and
//     WINDOW lit columns at the start of each revolution.
//   - Glyph codes: 0-9 are digits, GLYPH_COLON and GLYPH_BLANK follow.
//   - Column-driver FSM state encoding and the packed digit snapshot type.
package pov_pkg;
  localparam int GLYPH_W     = 5;
  localparam int GLYPH_PITCH = 6;
  localparam int NUM_GLYPHS  = 8;
  localparam int WINDOW      = 48;

  localparam logic [3:0] GLYPH_COLON = 4'd10;
  localparam logic [3:0] GLYPH_BLANK = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } pov_state_e;

  typedef struct packed {
    logic [4:0] ht;
    logic [4:0] ho;
    logic [4:0] mt;
    logic [4:0] mo;
    logic [4:0] st;
    logic [4:0] so;
  } pov_digits_t;

  // Out-of-range BCD values render as an empty glyph.
  function automatic logic [3:0] digit_glyph(input logic [4:0] d);
    return (d > 5'd9) ? GLYPH_BLANK : d[3:0];
  endfunction
endpackage

// File: rtl/pov_font_rom.sv
// Combinational 5x8 font ROM.
//   glyph[3:0] : glyph code (0-9 digits, GLYPH_COLON, anything else blank)
//   gcol[2:0]  : column inside the glyph slot; columns >= GLYPH_W are dark
//   col[7:0]   : LED pattern for that column, bit0 = top LED
module pov_font_rom
  import pov_pkg::*;
(
  input  logic [3:0] glyph,
  input  logic [2:0] gcol,
  output logic [7:0] col
);
  // Column 0 of the glyph sits in the top byte.
  logic [39:0] bitmap;

  always_comb begin
    case (glyph)
      4'd0:        bitmap = 40'h3E_51_49_45_3E;
      4'd1:        bitmap = 40'h00_42_7F_40_00;
      4'd2:        bitmap = 40'h42_61_51_49_46;
      4'd3:        bitmap = 40'h21_41_45_4B_31;
      4'd4:        bitmap = 40'h18_14_12_7F_10;
      4'd5:        bitmap = 40'h27_45_45_45_39;
      4'd6:        bitmap = 40'h3C_4A_49_49_30;
      4'd7:        bitmap = 40'h01_71_09_05_03;
      4'd8:        bitmap = 40'h36_49_49_49_36;
      4'd9:        bitmap = 40'h06_49_49_29_1E;
      GLYPH_COLON: bitmap = 40'h00_36_36_00_00;
      default:     bitmap = 40'h0;
    endcase
    col = 8'h00;
    if (gcol < 3'(GLYPH_W)) begin
      case (gcol)
        3'd0:    col = bitmap[39:32];
        3'd1:    col = bitmap[31:24];
        3'd2:    col = bitmap[23:16];
        3'd3:    col = bitmap[15:8];
        default: col = bitmap[7:0];
      endcase
    end
  end
endmodule

// File: rtl/pov_column_driver.sv
// POV LED bar driver: measures the rotation period from the hall index
// sensor, slices each revolution into 2^COL_SHIFT columns and renders
// "HH:MM:SS" in the first WINDOW columns; the rest of the revolution is dark.
//   sys_clk, rst_n     : clock, asynchronous active-low reset
//   hall_in            : raw index sensor (rising edge = column 0)
//   hours/minutes/seconds tens/ones : BCD digits, sampled on each index
//   led_col            : registered LED column, bit0 = top LED
//   col_strobe         : one-cycle pulse when led_col takes a new column
//   spinning           : high while a valid rotation period is held
// Build option: define POV_COLON_BLINK_EN to blank the colons while the
// snapshot seconds_ones is odd; otherwise the colons are always lit.
module pov_column_driver
  import pov_pkg::*;
#(
  parameter int PERIOD_W  = 24,
  parameter int COL_SHIFT = 7,
  parameter int SYNC_STG  = 2
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       hall_in,
  input  logic [4:0] hours_tens,
  input  logic [4:0] hours_ones,
  input  logic [4:0] minutes_tens,
  input  logic [4:0] minutes_ones,
  input  logic [4:0] seconds_tens,
  input  logic [4:0] seconds_ones,
  output logic [7:0] led_col,
  output logic       col_strobe,
  output logic       spinning
);
  localparam logic [PERIOD_W-1:0]  CNT_MAX = '1;
  localparam logic [PERIOD_W-1:0]  CNT_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};
  localparam logic [COL_SHIFT-1:0] COL_MAX = '1;

  logic [SYNC_STG-1:0]  sync_q, sync_d;
  logic                 hall_prev_q, hall_prev_d;
  pov_state_e           state_q, state_d;
  logic [PERIOD_W-1:0]  cnt_q, cnt_d;
  logic [PERIOD_W-1:0]  period_q, period_d;
  logic [PERIOD_W-1:0]  dcnt_q, dcnt_d;
  logic [COL_SHIFT-1:0] col_idx_q, col_idx_d;
  logic                 col_new_q, col_new_d;
  pov_digits_t          snap_q, snap_d;
  logic [7:0]           led_col_q, led_col_d;
  logic                 col_strobe_q, col_strobe_d;
  logic                 spinning_q, spinning_d;

  logic        idx_pulse, stall, in_win;
  int unsigned ci, g_i;
  logic [2:0]  gcol;
  logic [3:0]  glyph, colon_glyph;
  logic [7:0]  rom_col;

  function automatic logic [PERIOD_W-1:0] col_period_of(input logic [PERIOD_W-1:0] p);
    logic [PERIOD_W-1:0] c;
    c = p >> COL_SHIFT;
    return (c == '0) ? CNT_ONE : c;
  endfunction

  pov_font_rom u_rom (
    .glyph (glyph),
    .gcol  (gcol),
    .col   (rom_col)
  );

  // Index detection, period measurement and column sequencing.
  always_comb begin
    sync_d      = {sync_q[SYNC_STG-2:0], hall_in};
    hall_prev_d = sync_q[SYNC_STG-1];
    idx_pulse   = sync_q[SYNC_STG-1] & ~hall_prev_q;
    stall       = (cnt_q == CNT_MAX);

    state_d   = state_q;
    cnt_d     = stall ? cnt_q : cnt_q + 1'b1;
    period_d  = period_q;
    dcnt_d    = dcnt_q;
    col_idx_d = col_idx_q;
    col_new_d = 1'b0;
    snap_d    = snap_q;

    if (idx_pulse) begin
      // The pulse cycle is cycle 1 of the new revolution, so the latched
      // count equals the number of cycles between index edges.
      cnt_d     = CNT_ONE;
      period_d  = cnt_q;
      dcnt_d    = col_period_of(cnt_q);
      col_idx_d = '0;
      snap_d    = '{ht: hours_tens, ho: hours_ones, mt: minutes_tens,
                    mo: minutes_ones, st: seconds_tens, so: seconds_ones};
      if (state_q == ST_IDLE) begin
        state_d = ST_ARM;
      end else begin
        state_d   = ST_RUN;
        col_new_d = 1'b1;
      end
    end else if (stall) begin
      state_d   = ST_IDLE;
      period_d  = '0;
      col_idx_d = '0;
    end else if (state_q == ST_RUN) begin
      if (dcnt_q <= CNT_ONE) begin
        dcnt_d = col_period_of(period_q);
        // Last column holds (dark) until the next index; no wrap.
        if (col_idx_q != COL_MAX) begin
          col_idx_d = col_idx_q + 1'b1;
          col_new_d = 1'b1;
        end
      end else begin
        dcnt_d = dcnt_q - 1'b1;
      end
    end
  end

  // Column layout: glyph slot and column within slot.
  always_comb begin
    ci   = 32'(col_idx_q);
    g_i  = ci / GLYPH_PITCH;
    gcol = 3'(ci % GLYPH_PITCH);
    // WINDOW = NUM_GLYPHS * GLYPH_PITCH; both bounds describe the same window.
    in_win = (ci < WINDOW) && (g_i < NUM_GLYPHS);
`ifdef POV_COLON_BLINK_EN
    colon_glyph = snap_q.so[0] ? GLYPH_BLANK : GLYPH_COLON;
`else
    colon_glyph = GLYPH_COLON;
`endif
    case (g_i)
      0:       glyph = digit_glyph(snap_q.ht);
      1:       glyph = digit_glyph(snap_q.ho);
      2, 5:    glyph = colon_glyph;
      3:       glyph = digit_glyph(snap_q.mt);
      4:       glyph = digit_glyph(snap_q.mo);
      6:       glyph = digit_glyph(snap_q.st);
      7:       glyph = digit_glyph(snap_q.so);
      default: glyph = GLYPH_BLANK;
    endcase

    led_col_d    = (state_q == ST_RUN && !stall && in_win) ? rom_col : 8'h00;
    col_strobe_d = col_new_q && (state_q == ST_RUN);
    spinning_d   = (state_d == ST_RUN);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      hall_prev_q  <= 1'b0;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      period_q     <= '0;
      dcnt_q       <= '0;
      col_idx_q    <= '0;
      col_new_q    <= 1'b0;
      snap_q       <= '0;
      led_col_q    <= 8'h00;
      col_strobe_q <= 1'b0;
      spinning_q   <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      hall_prev_q  <= hall_prev_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      dcnt_q       <= dcnt_d;
      col_idx_q    <= col_idx_d;
      col_new_q    <= col_new_d;
      snap_q       <= snap_d;
      led_col_q    <= led_col_d;
      col_strobe_q <= col_strobe_d;
      spinning_q   <= spinning_d;
    end
  end

  assign led_col    = led_col_q;
  assign col_strobe = col_strobe_q;
  assign spinning   = spinning_q;
endmodule

// File: tb/tb_pov_column_driver.sv
`timescale 1ns/1ps
module tb_pov_column_driver;
  localparam int PW  = 12;
  localparam int CS  = 7;
  localparam int SAT = (1 << PW) - 1;

  // Font columns, bit0 = top LED; index 10 is the colon.
  localparam logic [7:0] FONT [11][5] = '{
    '{8'h3E, 8'h51, 8'h49, 8'h45, 8'h3E},
    '{8'h00, 8'h42, 8'h7F, 8'h40, 8'h00},
    '{8'h42, 8'h61, 8'h51, 8'h49, 8'h46},
    '{8'h21, 8'h41, 8'h45, 8'h4B, 8'h31},
    '{8'h18, 8'h14, 8'h12, 8'h7F, 8'h10},
    '{8'h27, 8'h45, 8'h45, 8'h45, 8'h39},
    '{8'h3C, 8'h4A, 8'h49, 8'h49, 8'h30},
    '{8'h01, 8'h71, 8'h09, 8'h05, 8'h03},
    '{8'h36, 8'h49, 8'h49, 8'h49, 8'h36},
    '{8'h06, 8'h49, 8'h49, 8'h29, 8'h1E},
    '{8'h00, 8'h36, 8'h36, 8'h00, 8'h00}
  };
  // Display slot -> digit position (Ht Ho Mt Mo St So), -1 = colon.
  localparam int SLOT_DIG [8] = '{0, 1, -1, 2, 3, -1, 4, 5};

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b1;
  logic       hall_in = 1'b0;
  logic [4:0] dig [6];
  logic [7:0] led_col;
  logic       col_strobe, spinning;

  int tests = 0, fails = 0;
  int cyc = 0;
  // reference model: revolution bookkeeping in cycle numbers
  int m_st = 0, m_last = 0, m_per = 0, pend = -1;
  bit m_hall_prev = 1'b0;
  int snap [6] = '{0, 0, 0, 0, 0, 0};
  logic [7:0] cap [128];
  int cap_n = 0, last_stb = -1, stb_gap = 0;
  logic [7:0] first_col = 8'h00;

  always #5 sys_clk = ~sys_clk;

  pov_column_driver #(.PERIOD_W(PW), .COL_SHIFT(CS), .SYNC_STG(2)) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .hall_in      (hall_in),
    .hours_tens   (dig[0]),
    .hours_ones   (dig[1]),
    .minutes_tens (dig[2]),
    .minutes_ones (dig[3]),
    .seconds_tens (dig[4]),
    .seconds_ones (dig[5]),
    .led_col      (led_col),
    .col_strobe   (col_strobe),
    .spinning     (spinning)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp_pattern(input int col);
    int g, gc, d;
    g  = col / 6;
    gc = col % 6;
    if (col >= 48 || gc == 5) return 8'h00;
    d = SLOT_DIG[g];
    if (d < 0) begin
`ifdef POV_COLON_BLINK_EN
      if (snap[5] % 2 == 1) return 8'h00;
`endif
      return FONT[10][gc];
    end
    if (snap[d] > 9) return 8'h00;
    return FONT[snap[d]][gc];
  endfunction

  // One clock: outputs after edge cyc reflect the model state after edge cyc-1.
  task automatic tick();
    int x, cp, k;
    logic [7:0] exp_led;
    bit exp_stb;
    @(posedge sys_clk);
    cyc++;
    @(negedge sys_clk);
    exp_led = 8'h00;
    exp_stb = 1'b0;
    if (m_st == 2) begin
      x = cyc - 1 - m_last;
      if (x < SAT - 1) begin
        cp = m_per >> CS;
        if (cp == 0) cp = 1;
        k = x / cp;
        exp_led = exp_pattern(k > 127 ? 127 : k);
        exp_stb = (x % cp == 0) && (k <= 127);
      end
    end
    // index takes effect two edges after the first edge that sees hall high
    if (hall_in && !m_hall_prev) pend = cyc + 2;
    m_hall_prev = hall_in;
    if (pend == cyc) begin
      for (int i = 0; i < 6; i++) snap[i] = int'(dig[i]);
      if (m_st != 0) m_per = cyc - m_last;
      m_st   = (m_st == 0) ? 1 : 2;
      m_last = cyc;
      pend   = -1;
    end else if (m_st != 0 && cyc - m_last >= SAT) begin
      m_st = 0;
    end
    chk("led_col", 32'(led_col), 32'(exp_led));
    chk("col_strobe", 32'(col_strobe), 32'(exp_stb));
    chk("spinning", 32'(spinning), 32'(m_st == 2));
    if (col_strobe) begin
      if (cap_n < 128) cap[cap_n] = led_col;
      cap_n++;
      if (last_stb >= 0) stb_gap = cyc - last_stb;
      last_stb = cyc;
    end
  endtask

  task automatic rev(input int n, input int chg_at);
    cap_n   = 0;
    hall_in = 1'b1;
    for (int t = 0; t < n; t++) begin
      if (t == 20) hall_in = 1'b0;
      if (t == chg_at) for (int i = 0; i < 6; i++) dig[i] = 5'($urandom_range(0, 15));
      tick();
      if (t == 3) first_col = led_col;
    end
  endtask

  task automatic set_digits(input int a, input int b, input int c,
                            input int d, input int e, input int f);
    dig[0] = 5'(a); dig[1] = 5'(b); dig[2] = 5'(c);
    dig[3] = 5'(d); dig[4] = 5'(e); dig[5] = 5'(f);
  endtask

  task automatic do_reset();
    hall_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_led", 32'(led_col), 32'h0);
    chk("rst_strobe", 32'(col_strobe), 32'h0);
    chk("rst_spin", 32'(spinning), 32'h0);
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b1;
    m_st = 0; m_last = 0; m_per = 0; pend = -1; m_hall_prev = 1'b0;
    for (int i = 0; i < 6; i++) snap[i] = 0;
  endtask

  initial begin
    set_digits(0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_led", 32'(led_col), 32'h0);
    chk("rst_strobe", 32'(col_strobe), 32'h0);
    chk("rst_spin", 32'(spinning), 32'h0);
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b1;

    // 1280-cycle revolutions: dark through the first index, lit after the second
    set_digits(0, 4, 3, 4, 4, 0);
    rev(1280, -1);
    chk("arm_spin", 32'(spinning), 32'h0);
    chk("arm_dark_strobes", 32'(cap_n), 32'h0);
    rev(1280, -1);
    chk("run_spin", 32'(spinning), 32'h1);
    chk("run_strobes", 32'(cap_n), 32'd128);
    chk("strobe_gap", 32'(stb_gap), 32'd10);
    // index coincides with a column expiry at 1280/10
    chk("coincident_col0", 32'(first_col), 32'h3E);
    for (int c = 0; c < 5; c++) chk("ht_zero", 32'(cap[c]), 32'(FONT[0][c]));
    chk("spacer5", 32'(cap[5]), 32'h00);
    chk("ho_four", 32'(cap[6]), 32'h18);
    chk("colon12", 32'(cap[12]), 32'h00);
    chk("colon13", 32'(cap[13]), 32'h36);
    chk("colon14", 32'(cap[14]), 32'h36);
    chk("spacer17", 32'(cap[17]), 32'h00);
    begin
      logic [7:0] tail;
      tail = 8'h00;
      for (int c = 48; c < 128; c++) tail |= cap[c];
      chk("dark_tail", 32'(tail), 32'h0);
    end

    // digits change mid-revolution: this revolution keeps the old snapshot
    rev(1280, 600);
    chk("torn_ht", 32'(cap[0]), 32'h3E);
    chk("torn_ho", 32'(cap[6]), 32'h18);

    // short revolution then a long one: 128 columns, then held dark at 127
    rev(640, -1);
    rev(1280, -1);
    chk("sat_strobes", 32'(cap_n), 32'd128);
    chk("sat_dark", 32'(led_col), 32'h0);

    // randomized periods and digits
    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(300, 3000);
      for (int i = 0; i < 6; i++) dig[i] = 5'($urandom_range(0, 15));
      rev(n, $urandom_range(50, n - 50));
    end

    // hall stops: counter saturates, driver stalls
    hall_in = 1'b0;
    repeat (SAT + 100) tick();
    chk("stall_spin", 32'(spinning), 32'h0);
    chk("stall_led", 32'(led_col), 32'h0);

    // reset mid-revolution, then two index edges before light
    rev(1280, -1);
    rev(1280, -1);
    hall_in = 1'b1;
    repeat (20) tick();
    hall_in = 1'b0;
    repeat (300) tick();
    do_reset();
    rev(1280, -1);
    chk("post_rst_spin", 32'(spinning), 32'h0);
    chk("post_rst_dark", 32'(cap_n), 32'h0);
    rev(1280, -1);
    chk("post_rst_run", 32'(spinning), 32'h1);
    chk("post_rst_strobes", 32'(cap_n), 32'd128);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
